// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//
// Arbitrates NUM_REQ write requesters onto the write port of a circular FIFO
// and tracks the FIFO occupancy. Requesters are served round robin. A winner
// may keep the port for up to MAX_BURST consecutive cycles. Grants, the
// write strobe, the write data and the gated read strobe are all
// combinational, so data is written in the same cycle it is granted.
//
// Parameters
//   DATA_WIDTH : width of each requester's data slice and the FIFO word
//   FIFO_DEPTH : FIFO depth (power of two, >= 4); usable capacity is DEPTH-1
//   NUM_REQ    : number of requesters (2..8)
//   MAX_BURST  : maximum consecutive grants to one requester (1..8)
//
// Ports
//   clk           : clock, all state updates on its rising edge
//   rst           : asynchronous active-low reset (0 = reset)
//   req           : per-requester write request
//   req_data      : flattened requester data, slice i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt           : one-hot-or-zero grant
//   fifo_write    : FIFO write strobe (OR of gnt)
//   fifo_write_in : granted data slice, zero when nothing is granted
//   read_req      : consumer read request
//   fifo_read     : read strobe, suppressed while the FIFO is empty
//   level         : registered FIFO occupancy
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            fifo_write,
  output logic [DATA_WIDTH-1:0]           fifo_write_in,
  input  logic                            read_req,
  output logic                            fifo_read,
  output logic [$clog2(FIFO_DEPTH)-1:0]   level
);

  localparam int LW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   owner, owner_next;
  logic [IW-1:0]   rr_ptr, rr_ptr_next;
  logic [BW-1:0]   burst_cnt, burst_cnt_next, burst_inc;
  logic [LW-1:0]   level_next;
  logic [IW-1:0]   winner, scan_idx, grant_idx;
  logic            found, grant_valid, space;

  // Requester index increment with wrap from NUM_REQ-1 back to 0
  // (NUM_REQ need not be a power of two).
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IW'(1);
  endfunction

  // One slot is kept empty so that a full FIFO is distinguishable from an
  // empty one by the attached read/write pointers.
  assign space = (level < FULL_LEVEL);

  // Round-robin scan: first requesting index at or after rr_ptr.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  // Next-state logic. Without space everything holds; a burst that loses its
  // request ends with an empty cycle and the pointer moves past the owner.
  always_comb begin
    state_next     = state;
    owner_next     = owner;
    rr_ptr_next    = rr_ptr;
    burst_cnt_next = burst_cnt;
    grant_valid    = 1'b0;
    grant_idx      = owner;
    burst_inc      = burst_cnt + BW'(1);
    if (space) begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_valid    = 1'b1;
            grant_idx      = winner;
            owner_next     = winner;
            burst_cnt_next = BW'(1);
            if (MAX_BURST == 1) rr_ptr_next = wrap_inc(winner);
            else                state_next  = BURST;
          end
        end
        BURST: begin
          if (req[owner]) begin
            grant_valid    = 1'b1;
            grant_idx      = owner;
            burst_cnt_next = burst_inc;
            if (burst_inc == BURST_LIMIT) begin
              state_next  = IDLE;
              rr_ptr_next = wrap_inc(owner);
            end
          end else begin
            state_next  = IDLE;
            rr_ptr_next = wrap_inc(owner);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Combinational outputs, all forced low while reset is held.
  always_comb begin
    gnt           = '0;
    fifo_write    = 1'b0;
    fifo_write_in = '0;
    fifo_read     = 1'b0;
    if (rst) begin
      if (grant_valid) begin
        gnt[grant_idx] = 1'b1;
        fifo_write     = 1'b1;
        fifo_write_in  = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
      fifo_read = read_req && (level != '0);
    end
  end

  // Occupancy tracking; simultaneous write and read cancel out.
  always_comb begin
    level_next = level;
    if (fifo_write && !fifo_read)      level_next = level + LW'(1);
    else if (!fifo_write && fifo_read) level_next = level - LW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      level     <= '0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      rr_ptr    <= rr_ptr_next;
      burst_cnt <= burst_cnt_next;
      level     <= level_next;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Bench for fifo_write_arbiter with default parameters (4 requesters, burst
// of 2, depth 16). Directed scenarios use fixed expected sequences; the random
// scenario runs against a behavioural model of the arbitration rules.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int NR    = 4;
  localparam int MB    = 2;
  localparam int DBITS = NR * DW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [DBITS-1:0] req_data = '0;
  logic             read_req = 1'b0;
  logic [NR-1:0]    gnt;
  logic             fifo_write;
  logic [DW-1:0]    fifo_write_in;
  logic             fifo_read;
  logic [3:0]       level;

  int passed = 0;
  int total  = 0;

  // Reference model state: who holds the port (-1 = nobody), how many
  // grants they have had in a row, where the next search starts, occupancy.
  int m_owner  = -1;
  int m_streak = 0;
  int m_next   = 0;
  int m_level  = 0;

  fifo_write_arbiter #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_REQ(NR), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_write(fifo_write), .fifo_write_in(fifo_write_in),
    .read_req(read_req), .fifo_read(fifo_read), .level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] slice_of(input logic [DBITS-1:0] d, input logic [NR-1:0] g);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NR; i++) if (g[i]) r = d[i*DW +: DW];
    return r;
  endfunction

  function automatic void model_reset();
    m_owner  = -1;
    m_streak = 0;
    m_next   = 0;
    m_level  = 0;
  endfunction

  // One cycle of the arbitration rules, expressed on plain integers.
  function automatic void model_step(input logic [NR-1:0] r, input logic rd,
                                     output logic [NR-1:0] eg, output logic er);
    int w;
    eg = '0;
    er = rd && (m_level != 0);
    if (m_level < DEPTH - 1) begin
      if (m_owner < 0) begin
        w = -1;
        for (int k = 0; k < NR; k++)
          if (w < 0 && r[(m_next + k) % NR]) w = (m_next + k) % NR;
        if (w >= 0) begin
          eg[w]    = 1'b1;
          m_streak = 1;
          if (MB == 1) m_next = (w + 1) % NR;
          else         m_owner = w;
        end
      end else if (r[m_owner]) begin
        eg[m_owner] = 1'b1;
        m_streak    = m_streak + 1;
        if (m_streak == MB) begin
          m_next  = (m_owner + 1) % NR;
          m_owner = -1;
        end
      end else begin
        m_next  = (m_owner + 1) % NR;
        m_owner = -1;
      end
    end
    m_level = m_level + ((eg != '0) ? 1 : 0) - (er ? 1 : 0);
  endfunction

  task automatic drive(input logic [NR-1:0] r, input logic rd);
    @(negedge clk);
    req      = r;
    read_req = rd;
    req_data = DBITS'($urandom);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req      = '0;
    read_req = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    rst      = 1'b0;
    req      = 4'b1111;
    read_req = 1'b1;
    req_data = DBITS'($urandom);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if ({gnt, fifo_write, fifo_write_in, fifo_read} !== '0)
        $display("[TB] FAIL reset_outputs: got gnt=%b wr=%b data=%h rd=%b, expected all 0",
                 gnt, fifo_write, fifo_write_in, fifo_read);
      else passed++;
      total++;
      if (level !== 4'd0) $display("[TB] FAIL reset_level: got %0d, expected 0", level);
      else passed++;
      @(negedge clk);
    end
    req      = '0;
    read_req = 1'b0;
    rst      = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_seq [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                   4'b0100, 4'b0100, 4'b1000, 4'b1000};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(4'b1111, 1'b0);
      total++;
      if ({gnt, fifo_write, fifo_write_in} !== {exp_seq[c], 1'b1, slice_of(req_data, exp_seq[c])})
        $display("[TB] FAIL rr_grant cycle %0d: got gnt=%b wr=%b data=%h, expected gnt=%b data=%h",
                 c, gnt, fifo_write, fifo_write_in, exp_seq[c], slice_of(req_data, exp_seq[c]));
      else passed++;
    end
    drive(4'b0000, 1'b0);
    total++;
    if (level !== 4'd8) $display("[TB] FAIL rr_level: got %0d, expected 8", level);
    else passed++;
  endtask

  task automatic test_burst_break();
    logic [NR-1:0] req_seq [4] = '{4'b0011, 4'b0010, 4'b0010, 4'b0010};
    logic [NR-1:0] exp_seq [4] = '{4'b0001, 4'b0000, 4'b0010, 4'b0010};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(req_seq[c], 1'b0);
      total++;
      if ({gnt, fifo_write_in} !== {exp_seq[c], slice_of(req_data, exp_seq[c])})
        $display("[TB] FAIL burst_break cycle %0d: got gnt=%b data=%h, expected gnt=%b data=%h",
                 c, gnt, fifo_write_in, exp_seq[c], slice_of(req_data, exp_seq[c]));
      else passed++;
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      drive(4'b0001, 1'b0);
      total++;
      if ({level, gnt} !== {4'(c), 4'b0001})
        $display("[TB] FAIL full_fill cycle %0d: got level=%0d gnt=%b, expected level=%0d gnt=0001",
                 c, level, gnt, c);
      else passed++;
    end
    for (int c = 0; c < 2; c++) begin
      drive(4'b0001, 1'b0);
      total++;
      if ({level, gnt, fifo_write} !== {4'd15, 4'b0000, 1'b0})
        $display("[TB] FAIL full_hold: got level=%0d gnt=%b wr=%b, expected level=15 gnt=0000 wr=0",
                 level, gnt, fifo_write);
      else passed++;
    end
    drive(4'b0001, 1'b1);
    total++;
    if ({gnt, fifo_read} !== {4'b0000, 1'b1})
      $display("[TB] FAIL full_read: got gnt=%b rd=%b, expected gnt=0000 rd=1", gnt, fifo_read);
    else passed++;
    drive(4'b0001, 1'b0);
    total++;
    if ({level, gnt} !== {4'd14, 4'b0001})
      $display("[TB] FAIL full_refill: got level=%0d gnt=%b, expected level=14 gnt=0001", level, gnt);
    else passed++;
    drive(4'b0000, 1'b0);
    total++;
    if (level !== 4'd15) $display("[TB] FAIL full_level: got %0d, expected 15", level);
    else passed++;
  endtask

  task automatic test_empty_simultaneous();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(4'b0000, 1'b1);
      total++;
      if ({level, fifo_read, gnt} !== {4'd0, 1'b0, 4'b0000})
        $display("[TB] FAIL empty_read: got level=%0d rd=%b gnt=%b, expected level=0 rd=0 gnt=0000",
                 level, fifo_read, gnt);
      else passed++;
    end
    for (int c = 0; c < 5; c++) begin
      drive(4'b0100, 1'b0);
      total++;
      if ({gnt, fifo_write_in} !== {4'b0100, req_data[2*DW +: DW]})
        $display("[TB] FAIL fill_five cycle %0d: got gnt=%b data=%h, expected gnt=0100 data=%h",
                 c, gnt, fifo_write_in, req_data[2*DW +: DW]);
      else passed++;
    end
    drive(4'b0100, 1'b1);
    total++;
    if ({level, gnt, fifo_read} !== {4'd5, 4'b0100, 1'b1})
      $display("[TB] FAIL simul_rw: got level=%0d gnt=%b rd=%b, expected level=5 gnt=0100 rd=1",
               level, gnt, fifo_read);
    else passed++;
    drive(4'b0000, 1'b0);
    total++;
    if (level !== 4'd5) $display("[TB] FAIL simul_level: got %0d, expected 5", level);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    logic [NR-1:0] req_seq [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0100};
    logic [NR-1:0] exp_seq [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0000, 4'b0100};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(req_seq[c], 1'b0);
      total++;
      if (gnt !== exp_seq[c])
        $display("[TB] FAIL midburst_setup cycle %0d: got gnt=%b, expected %b", c, gnt, exp_seq[c]);
      else passed++;
    end
    drive(4'b0100, 1'b0);
    total++;
    if ({level, gnt} !== {4'd6, 4'b0100})
      $display("[TB] FAIL midburst_state: got level=%0d gnt=%b, expected level=6 gnt=0100", level, gnt);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if ({level, gnt, fifo_write} !== {4'd0, 4'b0000, 1'b0})
      $display("[TB] FAIL midburst_async: got level=%0d gnt=%b wr=%b, expected level=0 gnt=0000 wr=0",
               level, gnt, fifo_write);
    else passed++;
    @(negedge clk);
    req = 4'b1111;
    rst = 1'b1;
    #1;
    total++;
    if (gnt !== 4'b0001)
      $display("[TB] FAIL midburst_restart: got gnt=%b, expected 0001", gnt);
    else passed++;
    model_reset();
  endtask

  task automatic test_random();
    logic [NR-1:0] r, eg;
    logic          rd, er;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      r  = NR'($urandom_range(0, 15));
      rd = (c < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(r, rd);
      total++;
      if (level !== 4'(m_level))
        $display("[TB] FAIL rand_level cycle %0d: got %0d, expected %0d", c, level, m_level);
      else passed++;
      model_step(r, rd, eg, er);
      total++;
      if ({gnt, fifo_write, fifo_write_in, fifo_read} !== {eg, |eg, slice_of(req_data, eg), er})
        $display("[TB] FAIL rand_out cycle %0d: got gnt=%b wr=%b data=%h rd=%b, expected gnt=%b wr=%b data=%h rd=%b",
                 c, gnt, fifo_write, fifo_write_in, fifo_read, eg, |eg, slice_of(req_data, eg), er);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst_break();
    test_full();
    test_empty_simultaneous();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
